// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: default widths and FSM state type.
// Latency: none (package). Backpressure: none.
package pc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          INC_DEF       = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    typedef enum logic {BOOT, RUN} pc_state_t;

    // Instruction fetch addresses must be word aligned.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Next-PC control inputs and fetch PC / RAS prediction outputs of pc_gen.
// Latency: none (wiring). Backpressure: stall is the only hold mechanism.
interface pc_gen_if import pc_pkg::*; #(parameter int XLEN = XLEN_DEF);

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vec;
    logic            call_i;
    logic            ret_i;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid;
    logic            misalign;
    logic [XLEN-1:0] ras_pred_pc;
    logic            ras_valid;

    modport master (
        output stall, redirect_valid, redirect_pc, trap_valid, trap_vec, call_i, ret_i,
        input  pc, pc_plus_inc, pc_valid, misalign, ras_pred_pc, ras_valid
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, trap_valid, trap_vec, call_i, ret_i,
        output pc, pc_plus_inc, pc_valid, misalign, ras_pred_pc, ras_valid
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace/flush, oldest entry overwritten when full.
// Latency: 1 cycle from push/pop to updated top. Backpressure: none; pops on empty are dropped.
module pc_ras import pc_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [XLEN-1:0] push_dat,
    output logic [XLEN-1:0] top_dat,
    output logic            top_vld
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tp;
    logic [PTR_W:0]   cnt;
    logic             empty;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign empty  = (cnt == '0);
    // A replace on an empty stack behaves like a push.
    assign wr_en  = push | replace;
    assign wr_idx = (push || empty) ? tp + 1'b1 : tp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push) begin
            tp  <= tp + 1'b1;
            if (cnt != (PTR_W+1)'(DEPTH))
                cnt <= cnt + 1'b1;
        end else if (replace) begin
            if (empty) begin
                tp  <= tp + 1'b1;
                cnt <= (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            tp  <= tp - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wr_idx] <= push_dat;
    end

    assign top_dat = empty ? '0 : mem[tp];
    assign top_vld = !empty;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with trap > redirect > stall > increment priority and optional RAS (PC_RAS_EN).
// Latency: 1 cycle from control inputs to pc. Backpressure: stall holds pc unless trap/redirect.
module pc_gen import pc_pkg::*; #(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int              INC       = INC_DEF,
    parameter int              RAS_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    pc_gen_if.slave bus
);

    pc_state_t       state;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            misalign_q;
    logic            redir_ok;
    logic            redir_bad;
    logic [XLEN-1:0] pc_plus_inc;

    assign redir_ok    = bus.redirect_valid &&  is_aligned(bus.redirect_pc[1:0]);
    assign redir_bad   = bus.redirect_valid && !is_aligned(bus.redirect_pc[1:0]);
    assign pc_plus_inc = pc_q + XLEN'(INC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                    misalign_q <= 1'b0;
                end
                RUN: begin
                    misalign_q <= 1'b0;
                    if (bus.trap_valid)
                        pc_q <= bus.trap_vec & ~XLEN'(3);
                    else if (redir_ok)
                        pc_q <= bus.redirect_pc;
                    else if (redir_bad)
                        misalign_q <= 1'b1;
                    else if (!bus.stall)
                        pc_q <= pc_plus_inc;
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_plus_inc;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.misalign    = misalign_q;

`ifdef PC_RAS_EN
    logic ras_upd;
    logic ras_flush;

    // Stalled cycles and rejected redirects never retire the call/return.
    assign ras_upd   = (state == RUN) && !bus.stall && !bus.trap_valid && !redir_bad;
    assign ras_flush = (state == RUN) && bus.trap_valid;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .flush    (ras_flush),
        .push     (ras_upd &&  bus.call_i && !bus.ret_i),
        .pop      (ras_upd && !bus.call_i &&  bus.ret_i),
        .replace  (ras_upd &&  bus.call_i &&  bus.ret_i),
        .push_dat (pc_plus_inc),
        .top_dat  (bus.ras_pred_pc),
        .top_vld  (bus.ras_valid)
    );
`else
    logic unused_ras;
    assign unused_ras      = ^{bus.call_i, bus.ret_i, RAS_DEPTH[0]};
    assign bus.ras_pred_pc = '0;
    assign bus.ras_valid   = 1'b0;
`endif

endmodule
